// File: rtl/sorting.sv
// Batch sorter: serially collects up to DEPTH samples, ranks the whole batch
// in one cycle with a parallel compare network, then streams the ordered
// batch out one value per clock (ascending or descending).
module sorting #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sortType,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_enable,
    output logic [WIDTH-1:0] data_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    count_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] sample_r [DEPTH];
    logic [WIDTH-1:0] sorted_r [DEPTH];
    logic [WIDTH-1:0] data_out_r;

    logic [CW-1:0]    rank_s   [DEPTH];
    logic [WIDTH-1:0] sorted_s [DEPTH];

    // True when key a must be placed strictly ahead of key b in the output order.
    function automatic logic key_before(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic             desc);
        logic r;
        if (desc) begin
            r = (a > b);
        end else begin
            r = (a < b);
        end
        return r;
    endfunction

    // Rank of every valid entry: keys strictly ahead of it, plus equal keys at
    // lower buffer positions so that ties keep their arrival order.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rank_s[i] = {CW{1'b0}};
            for (int j = 0; j < DEPTH; j++) begin
                if (CW'(j) < count_r) begin
                    if (key_before(sample_r[j], sample_r[i], sortType)) begin
                        rank_s[i] = rank_s[i] + CW'(1);
                    end else if ((j < i) && (sample_r[j] == sample_r[i])) begin
                        rank_s[i] = rank_s[i] + CW'(1);
                    end else begin
                        rank_s[i] = rank_s[i];
                    end
                end else begin
                    rank_s[i] = rank_s[i];
                end
            end
        end
    end

    // Scatter each valid entry to the output slot given by its rank; slots
    // beyond the batch length keep whatever they held before.
    always_comb begin
        for (int p = 0; p < DEPTH; p++) begin
            sorted_s[p] = sorted_r[p];
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_r) && (rank_s[i] == CW'(p))) begin
                    sorted_s[p] = sample_r[i];
                end else begin
                    sorted_s[p] = sorted_s[p];
                end
            end
        end
    end

    // Load / sort / stream state machine with registered output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_LOAD;
            count_r    <= {CW{1'b0}};
            idx_r      <= {IW{1'b0}};
            data_out_r <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                sample_r[i] <= {WIDTH{1'b0}};
                sorted_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (load_enable) begin
                        if (count_r < CW'(DEPTH)) begin
                            sample_r[count_r[IW-1:0]] <= data_in;
                            count_r                   <= count_r + CW'(1);
                        end else begin
                            count_r <= count_r;
                        end
                    end else if (count_r != {CW{1'b0}}) begin
                        for (int p = 0; p < DEPTH; p++) begin
                            sorted_r[p] <= sorted_s[p];
                        end
                        idx_r   <= {IW{1'b0}};
                        state_r <= ST_OUT;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_OUT: begin
                    data_out_r <= sorted_r[idx_r];
                    if (CW'(idx_r) == (count_r - CW'(1))) begin
                        state_r <= ST_LOAD;
                        count_r <= {CW{1'b0}};
                        idx_r   <= {IW{1'b0}};
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                    count_r <= {CW{1'b0}};
                    idx_r   <= {IW{1'b0}};
                end
            endcase
        end
    end

    assign data_out = data_out_r;

endmodule

// File: tb/tb_sorting.sv
// Self-checking bench for the batch sorter: directed scenarios plus random
// batches checked against a selection-sort reference model.
module tb_sorting;

    logic       clk = 1'b0;
    logic       reset;
    logic       sortType;
    logic [7:0] data_in;
    logic       load_enable;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] batch_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_out;

    always #5 clk = ~clk;

    sorting #(.WIDTH(8), .DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .sortType   (sortType),
        .data_in    (data_in),
        .load_enable(load_enable),
        .data_out   (data_out)
    );

    // Reference: keep the first 16 samples, then repeatedly pull the extreme one.
    function automatic void build_expected(input bit st);
        logic [7:0] pool[$];
        int best;
        pool = batch_q;
        while (pool.size() > 16) void'(pool.pop_back());
        exp_q.delete();
        while (pool.size() > 0) begin
            best = 0;
            for (int i = 1; i < pool.size(); i++)
                if (st ? (pool[i] > pool[best]) : (pool[i] < pool[best])) best = i;
            exp_q.push_back(pool[best]);
            pool.delete(best);
        end
    endfunction

    // Feed batch_q serially, then one cycle with load_enable low (the sort edge).
    task automatic drive_batch(input bit st);
        foreach (batch_q[k]) begin
            load_enable = 1'b1;
            data_in     = batch_q[k];
            sortType    = st;
            @(posedge clk); #1;
        end
        load_enable = 1'b0;
        data_in     = 8'($urandom);
        sortType    = st;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; sortType = 1'b0; data_in = 8'd0; load_enable = 1'b0;
        #12;
        n_cmp++;
        if (data_out !== 8'd0) begin
            n_bad++; $display("FAIL reset_value: got %0d expected 0", data_out);
        end
        #1 reset = 1'b1;
        @(posedge clk); #1;
        last_out = 8'd0;
    endtask

    task automatic test_ascending3();
        batch_q = '{8'd121, 8'd37, 8'd11};
        build_expected(1'b0);
        drive_batch(1'b0);
        n_cmp++;
        if (data_out !== last_out) begin
            n_bad++; $display("FAIL asc3_hold_sort_edge: got %0d expected %0d", data_out, last_out);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (data_out !== exp_q[k]) begin
                n_bad++; $display("FAIL asc3[%0d]: got %0d expected %0d", k, data_out, exp_q[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (data_out !== 8'd121) begin
                n_bad++; $display("FAIL asc3_hold: got %0d expected 121", data_out);
            end
        end
        last_out = 8'd121;
    endtask

    task automatic test_descending15();
        batch_q = '{8'd121, 8'd37, 8'd11, 8'd45, 8'd246, 8'd83, 8'd180, 8'd233,
                    8'd96, 8'd242, 8'd104, 8'd63, 8'd3, 8'd157, 8'd28};
        build_expected(1'b1);
        drive_batch(1'b1);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (data_out !== exp_q[k]) begin
                n_bad++; $display("FAIL desc15[%0d]: got %0d expected %0d", k, data_out, exp_q[k]);
            end
        end
        last_out = exp_q[exp_q.size()-1];
    endtask

    task automatic test_overflow_dups();
        batch_q = '{8'd5, 8'd5, 8'd0, 8'd255};
        for (int k = 0; k < 12; k++) batch_q.push_back(8'd7);
        batch_q.push_back(8'd1);
        build_expected(1'b0);
        drive_batch(1'b0);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (data_out !== exp_q[k]) begin
                n_bad++; $display("FAIL overflow[%0d]: got %0d expected %0d", k, data_out, exp_q[k]);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (data_out !== 8'd255) begin
            n_bad++; $display("FAIL overflow_len: got %0d expected 255 held", data_out);
        end
        last_out = 8'd255;
    endtask

    task automatic test_reset_mid_out();
        batch_q = '{8'd50, 8'd20, 8'd30};
        drive_batch(1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (data_out !== 8'd20) begin
            n_bad++; $display("FAIL rst_mid_first: got %0d expected 20", data_out);
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (data_out !== 8'd0) begin
            n_bad++; $display("FAIL rst_mid_async: got %0d expected 0", data_out);
        end
        #1 reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (data_out !== 8'd0) begin
            n_bad++; $display("FAIL rst_mid_no_partial: got %0d expected 0", data_out);
        end
        batch_q = '{8'd9, 8'd4};
        drive_batch(1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (data_out !== 8'd4) begin
            n_bad++; $display("FAIL rst_mid_after0: got %0d expected 4", data_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (data_out !== 8'd9) begin
            n_bad++; $display("FAIL rst_mid_after1: got %0d expected 9", data_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (data_out !== 8'd9) begin
            n_bad++; $display("FAIL rst_mid_after_hold: got %0d expected 9", data_out);
        end
        last_out = 8'd9;
    endtask

    task automatic test_back_to_back();
        reset = 1'b0; load_enable = 1'b0;
        #3 reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (data_out !== 8'd0) begin
                n_bad++; $display("FAIL idle[%0d]: got %0d expected 0", k, data_out);
            end
        end
        batch_q = '{8'd3, 8'd1};
        drive_batch(1'b0);
        // Offer samples while batch A streams; they must not be captured.
        for (int k = 0; k < 2; k++) begin
            load_enable = 1'b1; data_in = 8'd99 + 8'(k); sortType = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (data_out !== ((k == 0) ? 8'd1 : 8'd3)) begin
                n_bad++; $display("FAIL batchA[%0d]: got %0d expected %0d", k, data_out, (k == 0) ? 1 : 3);
            end
        end
        batch_q = '{8'd8, 8'd2};
        drive_batch(1'b1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (data_out !== ((k == 0) ? 8'd8 : 8'd2)) begin
                n_bad++; $display("FAIL batchB[%0d]: got %0d expected %0d", k, data_out, (k == 0) ? 8 : 2);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (data_out !== 8'd2) begin
            n_bad++; $display("FAIL batchB_len: got %0d expected 2 held", data_out);
        end
        last_out = 8'd2;
    endtask

    task automatic test_random();
        int n;
        bit st;
        for (int b = 0; b < 40; b++) begin
            n = $urandom_range(1, 20);
            st = 1'($urandom);
            batch_q.delete();
            for (int k = 0; k < n; k++) batch_q.push_back(8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom));
            build_expected(st);
            drive_batch(st);
            n_cmp++;
            if (data_out !== last_out) begin
                n_bad++; $display("FAIL rnd%0d_hold: got %0d expected %0d", b, data_out, last_out);
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                sortType = 1'($urandom); load_enable = 1'($urandom); data_in = 8'($urandom);
                @(posedge clk); #1;
                n_cmp++;
                if (data_out !== exp_q[k]) begin
                    n_bad++; $display("FAIL rnd%0d[%0d]: got %0d expected %0d", b, k, data_out, exp_q[k]);
                end
            end
            last_out = exp_q[exp_q.size()-1];
        end
    endtask

    initial begin
        test_reset();
        test_ascending3();
        test_descending15();
        test_overflow_dups();
        test_reset_mid_out();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
